// File: rtl/slave_ram_endpoint.sv
// Memory-backed slave endpoint for one cross-bar slave port: programmable-latency ack,
// read data returned one cycle after ack, saturating per-type transaction counters.
module slave_ram_endpoint #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned ACK_LAT    = 2,
  parameter logic [15:0] CNT_MAX    = 16'hFFFF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m_s_req,
  input  logic [ADDR_W-1:0] m_s_addr,
  input  logic              m_s_cmd,
  input  logic [DATA_W-1:0] m_s_wdata,
  output logic              s_m_ack,
  output logic [DATA_W-1:0] s_m_rdata,
  output logic              busy,
  output logic [15:0]       wr_cnt,
  output logic [15:0]       rd_cnt
);

  typedef enum logic [1:0] {StIdle, StWait, StAck, StResp} state_e;

  localparam logic [3:0] AckLat = 4'(ACK_LAT);

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic                    cmd_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [DATA_W-1:0]       rdata_q;
  logic                    ack_q;
  logic                    busy_q;
  logic [15:0]             wr_cnt_q;
  logic [15:0]             rd_cnt_q;
  logic [DATA_W-1:0]       mem [2**DEPTH_LOG2];

  // Byte-lane bits and the slave-select bits above the RAM index are ignored (aliasing).
  logic unused_addr;
  assign unused_addr = ^{m_s_addr[ADDR_W-1:DEPTH_LOG2+2], m_s_addr[1:0]};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (m_s_req) begin
            idx_q   <= m_s_addr[DEPTH_LOG2+1:2];
            cmd_q   <= m_s_cmd;
            wdata_q <= m_s_wdata;
            busy_q  <= 1'b1;
            if (ACK_LAT == 0) begin
              state_q <= StAck;
              ack_q   <= 1'b1;
            end else begin
              cnt_q   <= AckLat;
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd1) begin
            state_q <= StAck;
            ack_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StAck: begin
          if (cmd_q) begin
            if (wr_cnt_q != CNT_MAX) wr_cnt_q <= wr_cnt_q + 16'd1;
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            rdata_q <= mem[idx_q];
            if (rd_cnt_q != CNT_MAX) rd_cnt_q <= rd_cnt_q + 16'd1;
            state_q <= StResp;
          end
        end
        StResp: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Reset must suppress a write that would otherwise close in the ACK cycle.
  always_ff @(posedge clk) begin
    if (resetn && (state_q == StAck) && cmd_q) mem[idx_q] <= wdata_q;
  end

  assign s_m_ack   = ack_q;
  assign s_m_rdata = rdata_q;
  assign busy      = busy_q;
  assign wr_cnt    = wr_cnt_q;
  assign rd_cnt    = rd_cnt_q;

endmodule
